// File: rtl/lsu_access_ctrl.sv
// MEM-stage load/store controller: one outstanding req/ack data-memory access, lane steering and load extension.
// Optional misaligned-access trap is compiled in with `define LSU_MISALIGN_TRAP_EN.
module lsu_access_ctrl #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  input  logic        mem_write_i,
  input  logic [2:0]  width_src_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] load_data_o,
  output logic        bus_err_o,
  output logic        misalign_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2
  } size_e;

  // Counter value seen in the last ACCESS cycle before the abort.
  localparam logic [15:0] WaitLast = 16'(MAX_WAIT - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  size_e       size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] daddr_q, daddr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] load_q, load_d;
  logic        err_q, err_d;
  logic        mis_q, mis_d;

  size_e       req_size;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        req_misalign;

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;

  // Undefined codes 011/100/111 fall through to word.
  always_comb begin
    case (width_src_i[1:0])
      2'b01:   req_size = SZ_BYTE;
      2'b10:   req_size = SZ_HALF;
      default: req_size = SZ_WORD;
    endcase
  end

  always_comb begin
    req_be    = 4'b1111;
    req_wdata = store_data_i;
    case (req_size)
      SZ_BYTE: begin
        req_be    = 4'b0001 << addr_i[1:0];
        req_wdata = {4{store_data_i[7:0]}};
      end
      SZ_HALF: begin
        req_be    = 4'b0011 << {addr_i[1], 1'b0};
        req_wdata = {2{store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_misalign = ((req_size == SZ_HALF) && addr_i[0]) ||
                        ((req_size == SZ_WORD) && (addr_i[1:0] != 2'b00));
`else
  assign req_misalign = 1'b0;
`endif

  always_comb begin
    case (off_q)
      2'd0:    rd_byte = dmem_rdata_i[7:0];
      2'd1:    rd_byte = dmem_rdata_i[15:8];
      2'd2:    rd_byte = dmem_rdata_i[23:16];
      default: rd_byte = dmem_rdata_i[31:24];
    endcase
    rd_half = off_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (size_q)
      SZ_BYTE: rd_ext = uns_q ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      SZ_HALF: rd_ext = uns_q ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: rd_ext = dmem_rdata_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    req_d   = req_q;
    we_d    = we_q;
    daddr_d = daddr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    load_d  = load_q;
    err_d   = err_q;
    mis_d   = mis_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          size_d  = req_size;
          uns_d   = width_src_i[2];
          off_d   = addr_i[1:0];
          daddr_d = {addr_i[31:2], 2'b00};
          be_d    = req_be;
          wdata_d = req_wdata;
          if (req_misalign) begin
            state_d = ST_DONE;
            mis_d   = 1'b1;
            load_d  = 32'd0;
          end else begin
            state_d = ST_ACCESS;
            req_d   = 1'b1;
            we_d    = mem_write_i;
            cnt_d   = 16'd0;
          end
        end
      end

      ST_ACCESS: begin
        // An ack in the timeout cycle takes priority over the abort.
        if (dmem_ack_i) begin
          state_d = ST_DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          load_d  = we_q ? 32'd0 : rd_ext;
        end else if (cnt_q == WaitLast) begin
          state_d = ST_DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
          load_d  = 32'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        load_d  = 32'd0;
        err_d   = 1'b0;
        mis_d   = 1'b0;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 16'd0;
      size_q  <= SZ_WORD;
      uns_q   <= 1'b0;
      off_q   <= 2'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      daddr_q <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      load_q  <= 32'd0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      req_q   <= req_d;
      we_q    <= we_d;
      daddr_q <= daddr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      load_q  <= load_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
    end
  end

  // Stall drops in DONE so the pipeline advances at the end of the completion cycle.
  assign stall_o      = ((state_q == ST_IDLE) && req_valid_i) || (state_q == ST_ACCESS);
  assign done_o       = (state_q == ST_DONE);
  assign load_data_o  = load_q;
  assign bus_err_o    = err_q;
  assign misalign_o   = mis_q;
  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = daddr_q;
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;

endmodule

// File: tb/tb_lsu_access_ctrl.sv
// Self-checking bench for lsu_access_ctrl: table-driven accesses with a scoreboard, plus timeout and reset sequences.
`timescale 1ns/1ps
module tb_lsu_access_ctrl;

  localparam int MaxWait = 4;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        req_valid_i;
  logic        mem_write_i;
  logic [2:0]  width_src_i;
  logic [31:0] addr_i;
  logic [31:0] store_data_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] load_data_o;
  logic        bus_err_o;
  logic        misalign_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;

  lsu_access_ctrl #(.MAX_WAIT(MaxWait)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .req_valid_i  (req_valid_i),
    .mem_write_i  (mem_write_i),
    .width_src_i  (width_src_i),
    .addr_i       (addr_i),
    .store_data_i (store_data_i),
    .stall_o      (stall_o),
    .done_o       (done_o),
    .load_data_o  (load_data_o),
    .bus_err_o    (bus_err_o),
    .misalign_o   (misalign_o),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_be_o    (dmem_be_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_ack_i   (dmem_ack_i),
    .dmem_rdata_i (dmem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [2:0]  width;
    logic [31:0] addr;
    logic [31:0] sdata;
    int          ack_cyc;   // cycle in which ack is driven; 0 = never
    logic [31:0] rdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_daddr;
    int          exp_done;  // cycle in which done_o is expected
    logic [31:0] exp_load;
    logic        exp_err;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    logic [31:0] load;
    logic        err;
    logic        mis;
    int          done_cyc;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    sb_t exp;
    bit  done_seen;
    bit  saw_req;
    done_seen = 1'b0;
    saw_req   = 1'b0;
    @(negedge clk_i);
    req_valid_i  = 1'b1;
    mem_write_i  = v.we;
    width_src_i  = v.width;
    addr_i       = v.addr;
    store_data_i = v.sdata;
    sb_q.push_back('{v.exp_load, v.exp_err, v.exp_mis, v.exp_done});
    #1;
    chk($sformatf("v%0d_stall_c0", idx), 32'(stall_o), 32'd1);
    chk($sformatf("v%0d_req_c0", idx), 32'(dmem_req_o), 32'd0);
    for (int c = 1; c <= 20 && !done_seen; c++) begin
      @(negedge clk_i);
      dmem_ack_i   = 1'b0;
      dmem_rdata_i = 32'h5A5A5A5A;
      if (done_o) begin
        done_seen = 1'b1;
        chk($sformatf("v%0d_sb_depth", idx), 32'(sb_q.size()), 32'd1);
        if (sb_q.size() != 0) begin
          exp = sb_q.pop_front();
          chk($sformatf("v%0d_done_cyc", idx), 32'(c), 32'(exp.done_cyc));
          chk($sformatf("v%0d_load", idx), load_data_o, exp.load);
          chk($sformatf("v%0d_bus_err", idx), 32'(bus_err_o), 32'(exp.err));
          chk($sformatf("v%0d_misalign", idx), 32'(misalign_o), 32'(exp.mis));
        end
        chk($sformatf("v%0d_stall_done", idx), 32'(stall_o), 32'd0);
        chk($sformatf("v%0d_req_done", idx), 32'(dmem_req_o), 32'd0);
      end else begin
        chk($sformatf("v%0d_stall_c%0d", idx, c), 32'(stall_o), 32'd1);
        if (dmem_req_o) begin
          saw_req = 1'b1;
          chk($sformatf("v%0d_addr_c%0d", idx, c), dmem_addr_o, v.exp_daddr);
          chk($sformatf("v%0d_be_c%0d", idx, c), 32'(dmem_be_o), 32'(v.exp_be));
          chk($sformatf("v%0d_we_c%0d", idx, c), 32'(dmem_we_o), 32'(v.we));
          if (v.we) chk($sformatf("v%0d_wdata_c%0d", idx, c), dmem_wdata_o, v.exp_wdata);
        end
        if (c == v.ack_cyc) begin
          dmem_ack_i   = 1'b1;
          dmem_rdata_i = v.rdata;
        end
      end
    end
    dmem_ack_i = 1'b0;
    chk($sformatf("v%0d_done_seen", idx), 32'(done_seen), 32'd1);
    chk($sformatf("v%0d_req_issued", idx), 32'(saw_req), 32'(!v.exp_mis));
    // req_valid_i was still high during DONE; it must not have started a new access.
    @(negedge clk_i);
    chk($sformatf("v%0d_post_done", idx), 32'(done_o), 32'd0);
    chk($sformatf("v%0d_post_req", idx), 32'(dmem_req_o), 32'd0);
    req_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //              we    width   addr          sdata         ack      rdata          be     wdata          daddr         done       load           err   mis
    vecs.push_back('{1'b0, 3'b000, 32'h00000100, 32'h0,        1,       32'hDEADBEEF, 4'hF, 32'h0,        32'h00000100, 2,         32'hDEADBEEF, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 3'b001, 32'h00000103, 32'h0,        1,       32'h80FFFFFF, 4'h8, 32'h0,        32'h00000100, 2,         32'hFFFFFF80, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 3'b101, 32'h00000103, 32'h0,        1,       32'h80FFFFFF, 4'h8, 32'h0,        32'h00000100, 2,         32'h00000080, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 3'b010, 32'h00000202, 32'h1234ABCD, 2,       32'hFFFFFFFF, 4'hC, 32'hABCDABCD, 32'h00000200, 3,         32'h0,        1'b0, 1'b0});
    vecs.push_back('{1'b0, 3'b010, 32'h00000002, 32'h0,        3,       32'h80017FFF, 4'hC, 32'h0,        32'h00000000, 4,         32'hFFFF8001, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 3'b110, 32'h00000000, 32'h0,        1,       32'h8001F00F, 4'h3, 32'h0,        32'h00000000, 2,         32'h0000F00F, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 3'b001, 32'h00000001, 32'h000000A5, 1,       32'h0,        4'h2, 32'hA5A5A5A5, 32'h00000000, 2,         32'h0,        1'b0, 1'b0});
    vecs.push_back('{1'b1, 3'b101, 32'h00000002, 32'h11223344, 1,       32'h0,        4'h4, 32'h44444444, 32'h00000000, 2,         32'h0,        1'b0, 1'b0});
    vecs.push_back('{1'b0, 3'b101, 32'h00000101, 32'h0,        1,       32'h12345678, 4'h2, 32'h0,        32'h00000100, 2,         32'h00000056, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 3'b011, 32'h00000010, 32'h0,        1,       32'hCAFEF00D, 4'hF, 32'h0,        32'h00000010, 2,         32'hCAFEF00D, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 3'b100, 32'h00000014, 32'h89ABCDEF, 1,       32'h0,        4'hF, 32'h89ABCDEF, 32'h00000014, 2,         32'h0,        1'b0, 1'b0});
    vecs.push_back('{1'b0, 3'b111, 32'h00000020, 32'h0,        2,       32'h80000000, 4'hF, 32'h0,        32'h00000020, 3,         32'h80000000, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 3'b000, 32'h00000040, 32'h0,        0,       32'h0,        4'hF, 32'h0,        32'h00000040, MaxWait+1, 32'h0,        1'b1, 1'b0});
    vecs.push_back('{1'b0, 3'b000, 32'h00000044, 32'h0,        MaxWait, 32'h13572468, 4'hF, 32'h0,        32'h00000044, MaxWait+1, 32'h13572468, 1'b0, 1'b0});
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back('{1'b0, 3'b000, 32'h00000101, 32'h0,        1,       32'h0BADF00D, 4'hF, 32'h0,        32'h00000100, 1,         32'h0,        1'b0, 1'b1});
    vecs.push_back('{1'b0, 3'b010, 32'h00000103, 32'h0,        1,       32'hFEDC0000, 4'hC, 32'h0,        32'h00000100, 1,         32'h0,        1'b0, 1'b1});
`else
    vecs.push_back('{1'b0, 3'b000, 32'h00000101, 32'h0,        1,       32'h0BADF00D, 4'hF, 32'h0,        32'h00000100, 2,         32'h0BADF00D, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 3'b010, 32'h00000103, 32'h0,        1,       32'hFEDC0000, 4'hC, 32'h0,        32'h00000100, 2,         32'hFFFFFEDC, 1'b0, 1'b0});
`endif

    rst_n_i      = 1'b0;
    req_valid_i  = 1'b0;
    mem_write_i  = 1'b0;
    width_src_i  = 3'b000;
    addr_i       = 32'h0;
    store_data_i = 32'h0;
    dmem_ack_i   = 1'b0;
    dmem_rdata_i = 32'h0;
    #12;
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_load", load_data_o, 32'd0);
    chk("rst_bus_err", 32'(bus_err_o), 32'd0);
    chk("rst_misalign", 32'(misalign_o), 32'd0);
    chk("rst_req", 32'(dmem_req_o), 32'd0);
    chk("rst_we", 32'(dmem_we_o), 32'd0);
    chk("rst_addr", dmem_addr_o, 32'd0);
    chk("rst_be", 32'(dmem_be_o), 32'd0);
    chk("rst_wdata", dmem_wdata_o, 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Reset in the middle of an access, then a late ack.
    @(negedge clk_i);
    req_valid_i = 1'b1;
    mem_write_i = 1'b0;
    width_src_i = 3'b000;
    addr_i      = 32'h00000300;
    @(negedge clk_i);
    chk("midrst_req_before", 32'(dmem_req_o), 32'd1);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("midrst_req_async", 32'(dmem_req_o), 32'd0);
    chk("midrst_done", 32'(done_o), 32'd0);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    rst_n_i      = 1'b1;
    dmem_ack_i   = 1'b1;
    dmem_rdata_i = 32'h11111111;
    @(negedge clk_i);
    dmem_ack_i = 1'b0;
    chk("late_ack_done", 32'(done_o), 32'd0);
    chk("late_ack_req", 32'(dmem_req_o), 32'd0);
    chk("late_ack_load", load_data_o, 32'd0);
    @(negedge clk_i);
    chk("late_ack_done2", 32'(done_o), 32'd0);
    chk("late_ack_stall", 32'(stall_o), 32'd0);

    run_vec(100, vecs[0]);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
